prelude_loader: RTL and testbench

Boot and debug controller for the Prelude CPU. It accepts a byte-wide command stream over a valid/ready handshake and writes program bytes into the writable program memory that replaces the fixed ROM image. It also sequences the core's reset and clock-enable so the core can be loaded, run, halted and single-stepped without resynthesis. It sits between the host/UART byte interface and the Prelude core's `reset` and enable inputs.

---
 rtl/prelude_loader_if.sv | 29 ++
 rtl/prelude_loader.sv | 141 ++++++++++++++
 tb/tb_prelude_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prelude_loader_if.sv
// Byte command link from the host plus the program-memory write port and core controls
// driven by the Prelude boot/debug loader.
interface prelude_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              cpu_en;
    logic              load_done;
    logic              err;

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, mem_we, mem_addr, mem_wdata,
        output cpu_reset, cpu_en, load_done, err
    );

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_reset, cpu_en, load_done, err
    );
endinterface

// File: rtl/prelude_loader.sv
// Prelude boot/debug controller: decodes L/R/H/S commands, streams a length-prefixed
// payload into program memory and sequences the core's reset and clock enable.
module prelude_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    prelude_loader_if.slave bus
);
    localparam int REM_W = ADDR_W + 1;

    localparam logic [DATA_W-1:0] OP_LOAD = DATA_W'(8'h4C);
    localparam logic [DATA_W-1:0] OP_RUN  = DATA_W'(8'h52);
    localparam logic [DATA_W-1:0] OP_HALT = DATA_W'(8'h48);
    localparam logic [DATA_W-1:0] OP_STEP = DATA_W'(8'h53);

    typedef enum logic [1:0] {
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_STEP
    } state_t;

    state_t             r_state;
    logic               r_run;
    logic [ADDR_W-1:0]  r_addr;
    logic [REM_W-1:0]   r_remaining;
    logic               r_cmd_ready;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_cpu_reset;
    logic               r_cpu_en;
    logic               r_load_done;
    logic               r_err;

    logic               w_accept;

    assign w_accept = bus.cmd_valid & r_cmd_ready;

    // Every output is a register so the core and memory see glitch-free controls;
    // cmd_ready and cpu_en are therefore computed from the state being entered.
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_CMD;
            r_run       <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_cmd_ready <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_reset <= 1'b1;
            r_cpu_en    <= 1'b0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_ready <= 1'b1;
            r_mem_we    <= 1'b0;
            r_load_done <= 1'b0;

            case (r_state)
                ST_CMD: begin
                    if (w_accept) begin
                        case (bus.cmd_data)
                            OP_LOAD: begin
                                r_cpu_reset <= 1'b1;
                                r_run       <= 1'b0;
                                r_cpu_en    <= 1'b0;
                                r_err       <= 1'b0;
                                r_state     <= ST_LEN;
                            end
                            OP_RUN: begin
                                r_cpu_reset <= 1'b0;
                                r_run       <= 1'b1;
                                r_cpu_en    <= 1'b1;
                                r_err       <= 1'b0;
                            end
                            OP_HALT: begin
                                r_run       <= 1'b0;
                                r_cpu_en    <= 1'b0;
                                r_err       <= 1'b0;
                            end
                            OP_STEP: begin
                                r_cpu_reset <= 1'b0;
                                r_run       <= 1'b0;
                                r_cpu_en    <= 1'b1;
                                r_err       <= 1'b0;
                                r_cmd_ready <= 1'b0;
                                r_state     <= ST_STEP;
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end

                ST_LEN: begin
                    if (w_accept) begin
                        // A zero length byte means a full-depth load.
                        r_remaining <= (bus.cmd_data == '0) ? REM_W'(1 << ADDR_W)
                                                            : REM_W'(bus.cmd_data);
                        r_addr      <= '0;
                        r_state     <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= bus.cmd_data;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - REM_W'(1);
                        if (r_remaining == REM_W'(1)) begin
                            r_load_done <= 1'b1;
                            r_state     <= ST_CMD;
                        end
                    end
                end

                ST_STEP: begin
                    r_cpu_en <= r_run;
                    r_state  <= ST_CMD;
                end

                default: r_state <= ST_CMD;
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.cpu_en    = r_cpu_en;
    assign bus.load_done = r_load_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_prelude_loader.sv
// Self-checking bench for prelude_loader: vector table, directed multi-cycle sequences and
// a randomized command stream checked against a protocol-level reference model.
module tb_prelude_loader;
    localparam logic [7:0] C_L = 8'h4C;
    localparam logic [7:0] C_R = 8'h52;
    localparam logic [7:0] C_H = 8'h48;
    localparam logic [7:0] C_S = 8'h53;

    logic clk;
    logic reset;

    prelude_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    prelude_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural program memory plus write/done/PC observers.
    logic [7:0]  tb_mem  [256];
    logic [7:0]  exp_mem [256];
    logic [15:0] wr_q [$];
    int          done_cnt  = 0;
    int          done_addr = 0;
    int          done_orphan = 0;
    int          pc = 0;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            tb_mem[bus.mem_addr] = bus.mem_wdata;
            wr_q.push_back({bus.mem_addr, bus.mem_wdata});
        end
        if (bus.load_done) begin
            done_cnt++;
            done_addr = int'(bus.mem_addr);
            if (!bus.mem_we) done_orphan++;
        end
        if (bus.cpu_en && !bus.cpu_reset) pc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic we,
                              input logic [7:0] a, input logic [7:0] w,
                              input logic crst, input logic en,
                              input logic done, input logic e);
        check({tag, ".cmd_ready"}, bus.cmd_ready, rdy);
        check({tag, ".mem_we"},    bus.mem_we,    we);
        check({tag, ".mem_addr"},  bus.mem_addr,  a);
        check({tag, ".mem_wdata"}, bus.mem_wdata, w);
        check({tag, ".cpu_reset"}, bus.cpu_reset, crst);
        check({tag, ".cpu_en"},    bus.cpu_en,    en);
        check({tag, ".load_done"}, bus.load_done, done);
        check({tag, ".err"},       bus.err,       e);
    endtask

    // Present one byte and hold it until accepted, with a bounded wait.
    task automatic send(input logic [7:0] d);
        bit ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       rdy;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       crst;
        logic       en;
        logic       done;
        logic       e;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rdy,
                                input logic we, input logic [7:0] a, input logic [7:0] w,
                                input logic crst, input logic en, input logic done,
                                input logic e);
        vec_t t;
        t.valid = v;   t.data = d;   t.rdy = rdy; t.we = we;     t.addr = a;
        t.wdata = w;   t.crst = crst; t.en = en;  t.done = done; t.e = e;
        return t;
    endfunction

    // Reference model: tracks where the host is in the protocol, not the RTL's encoding.
    bit         m_want_len;
    int         m_left;
    int         m_ptr;
    bit         m_step;
    bit         m_run;
    bit         m_rst;
    bit         m_err;
    bit         m_we;
    bit         m_done;
    logic [7:0] m_waddr;
    logic [7:0] m_wdata;

    task automatic model_reset();
        m_want_len = 0; m_left = 0; m_ptr = 0; m_step = 0;
        m_run = 0; m_rst = 1; m_err = 0; m_we = 0; m_done = 0;
        m_waddr = '0; m_wdata = '0;
    endtask

    task automatic model_edge(input bit acc, input logic [7:0] d);
        m_we   = 0;
        m_done = 0;
        if (m_step) begin
            m_step = 0;
        end else if (acc) begin
            if (m_want_len) begin
                m_left     = (d == 8'h00) ? 256 : int'(d);
                m_ptr      = 0;
                m_want_len = 0;
            end else if (m_left > 0) begin
                exp_mem[m_ptr] = d;
                m_we    = 1;
                m_waddr = 8'(m_ptr);
                m_wdata = d;
                m_ptr   = (m_ptr + 1) % 256;
                m_left--;
                m_done  = (m_left == 0);
            end else if (d == C_L) begin
                m_rst = 1; m_run = 0; m_err = 0; m_want_len = 1;
            end else if (d == C_R) begin
                m_rst = 0; m_run = 1; m_err = 0;
            end else if (d == C_H) begin
                m_run = 0; m_err = 0;
            end else if (d == C_S) begin
                m_rst = 0; m_run = 0; m_err = 0; m_step = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   bad;
        int   cnt;
        int   pc0;
        int   d0;
        bit   v;
        bit   acc;
        logic [7:0] d;

        for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;

        // Power-on reset and release.
        repeat (2) @(posedge clk);
        #1;
        check_outs("por", 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        #3 reset = 1'b0;
        #1 check("por_ready_before_edge", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        check("por_ready_after_release", bus.cmd_ready, 1);

        // Vector table: inputs for one edge, registered outputs expected after it.
        tbl.push_back(mk(1, C_L,   1, 0, 8'h00, 8'h00, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h03, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h05, 1, 1, 8'h00, 8'h05, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h40, 1, 1, 8'h01, 8'h40, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hC4, 1, 1, 8'h02, 8'hC4, 1, 0, 1, 0));
        tbl.push_back(mk(1, C_R,   1, 0, 8'h02, 8'hC4, 0, 1, 0, 0));
        tbl.push_back(mk(0, C_R,   1, 0, 8'h02, 8'hC4, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h7A, 1, 0, 8'h02, 8'hC4, 0, 1, 0, 1));
        tbl.push_back(mk(1, C_H,   1, 0, 8'h02, 8'hC4, 0, 0, 0, 0));
        tbl.push_back(mk(1, C_H,   1, 0, 8'h02, 8'hC4, 0, 0, 0, 0));
        tbl.push_back(mk(1, C_L,   1, 0, 8'h02, 8'hC4, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h01, 1, 0, 8'h02, 8'hC4, 1, 0, 0, 0));
        tbl.push_back(mk(1, C_L,   1, 1, 8'h00, 8'h4C, 1, 0, 1, 0));
        tbl.push_back(mk(1, 8'h7A, 1, 0, 8'h00, 8'h4C, 1, 0, 0, 1));
        tbl.push_back(mk(1, C_S,   0, 0, 8'h00, 8'h4C, 0, 1, 0, 0));
        tbl.push_back(mk(1, C_S,   1, 0, 8'h00, 8'h4C, 0, 0, 0, 0));
        tbl.push_back(mk(1, C_S,   0, 0, 8'h00, 8'h4C, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 8'h4C, 0, 0, 0, 0));
        tbl.push_back(mk(1, C_R,   1, 0, 8'h00, 8'h4C, 0, 1, 0, 0));
        tbl.push_back(mk(1, C_S,   0, 0, 8'h00, 8'h4C, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 8'h4C, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            bus.cmd_valid = tbl[i].valid;
            bus.cmd_data  = tbl[i].data;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].we, tbl[i].addr,
                       tbl[i].wdata, tbl[i].crst, tbl[i].en, tbl[i].done, tbl[i].e);
        end
        bus.cmd_valid = 1'b0;
        check("vec_mem0", tb_mem[0], 8'h4C);
        check("vec_mem1", tb_mem[1], 8'h40);
        check("vec_mem2", tb_mem[2], 8'hC4);

        // 256-byte load with random valid gaps.
        wr_q.delete();
        d0 = done_cnt;
        send(C_L);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            idle($urandom_range(0, 2));
            send(8'(i));
        end
        idle(2);
        check("l256_writes", wr_q.size(), 256);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] !== {8'(i), 8'(i)}) bad++;
        check("l256_addr_data", bad, 0);
        check("l256_done_cnt", done_cnt - d0, 1);
        check("l256_done_addr", done_addr, 255);
        check("done_without_we", done_orphan, 0);
        check("l256_cpu_reset", bus.cpu_reset, 1);
        send(C_R);
        check("l256_back_in_cmd", bus.cpu_en, 1);
        send(C_H);
        check("l256_halt", bus.cpu_en, 0);

        // Three single steps with cmd_valid held high.
        pc0 = pc;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = C_S;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("step%0d.cpu_en", j), bus.cpu_en, (j % 2) == 0);
            check($sformatf("step%0d.cmd_ready", j), bus.cmd_ready, (j % 2) != 0);
        end
        idle(2);
        check("step_pc_delta", pc - pc0, 3);

        // Run for ten cycles, then halt; a second halt changes nothing.
        send(C_R);
        cnt = 0;
        bad = 0;
        for (int j = 0; j < 13; j++) begin
            if (bus.cpu_en) cnt++;
            if (bus.cpu_reset) bad++;
            bus.cmd_valid = (j == 9);
            bus.cmd_data  = C_H;
            @(posedge clk);
            #1;
        end
        check("run_en_cycles", cnt, 10);
        check("run_cpu_reset_high", bad, 0);
        send(C_H);
        check("halt2_cpu_en", bus.cpu_en, 0);
        check("halt2_cpu_reset", bus.cpu_reset, 0);

        // Randomized command stream against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 256; i++) exp_mem[i] = tb_mem[i];
        for (int c = 0; c < 800; c++) begin
            v = ($urandom % 4) != 0;
            if (m_want_len)
                d = (($urandom % 5) == 0) ? C_L : 8'($urandom_range(1, 6));
            else if (m_left > 0)
                d = 8'($urandom);
            else
                case ($urandom % 6)
                    0: d = C_L;
                    1: d = C_R;
                    2: d = C_H;
                    3: d = C_S;
                    default: d = 8'($urandom);
                endcase
            bus.cmd_valid = v;
            bus.cmd_data  = d;
            check("rnd.ready_pre", bus.cmd_ready, !m_step);
            acc = v && !m_step;
            @(posedge clk);
            #1;
            model_edge(acc, d);
            check_outs("rnd", !m_step, m_we, m_waddr, m_wdata, m_rst, m_run | m_step,
                       m_done, m_err);
        end
        idle(2);
        bad = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== exp_mem[i]) bad++;
        check("rnd_mem_image", bad, 0);

        // Reset in the middle of a load.
        do_reset();
        d0 = done_cnt;
        send(C_L);
        send(8'h05);
        send(8'hAA);
        send(8'hBB);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_outs("midrst", 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check("midrst_ready_held", bus.cmd_ready, 0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready_after", bus.cmd_ready, 1);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_mem0", tb_mem[0], 8'hAA);
        check("midrst_mem1", tb_mem[1], 8'hBB);
        send(C_R);
        check("midrst_count_lost_en", bus.cpu_en, 1);
        check("midrst_count_lost_we", bus.mem_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
